// File: rtl/serial_add_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_sub_ctrl
//
// Bit-serial adder/subtractor with a small IDLE/CALC/DONE controller.
// An operation is accepted in IDLE when in_valid is high. The two operands
// are then combined one bit per clock, LSB first, over WIDTH cycles. The
// result is presented for exactly one cycle in DONE. Subtraction is done as
// A + ~B + 1: B is inverted at capture and the carry is seeded with 1.
//
// Ports
//   clk       : single clock, all state changes on its rising edge
//   rst       : asynchronous, active-high reset
//   in_valid  : in_a / in_b / in_mode are valid this cycle
//   in_a      : unsigned operand A, WIDTH bits
//   in_b      : unsigned operand B, WIDTH bits
//   in_mode   : 0 = A+B, 1 = A-B
//   busy      : high in CALC and DONE. in_valid is ignored while high
//   out_valid : one-cycle result strobe (DONE state)
//   out_sum   : {carry_out, WIDTH-bit result}, forced to zero unless out_valid
// ---------------------------------------------------------------------------
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH:0]   out_sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sa_next;
  logic [WIDTH-1:0] sb_reg, sb_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             c_reg, c_next;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH:0]   result;

  // One full-adder slice working on the current LSBs of the operand shifters.
  assign bit_sum   = sa_reg[0] ^ sb_reg[0] ^ c_reg;
  assign bit_carry = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      c_reg     <= c_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    r_next     = r_reg;
    cnt_next   = cnt_reg;
    c_next     = c_reg;

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sa_next    = in_a;
          // Two's-complement subtract: invert B here, the +1 comes from the carry seed.
          sb_next    = in_mode ? ~in_b : in_b;
          cnt_next   = '0;
          c_next     = in_mode;
          state_next = CALC;
        end
      end
      CALC: begin
        // Sum bits enter from the top so that after WIDTH shifts the first
        // (least significant) bit has reached position 0.
        r_next   = {bit_sum, r_reg[WIDTH-1:1]};
        sa_next  = sa_reg >> 1;
        sb_next  = sb_reg >> 1;
        c_next   = bit_carry;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = {c_reg, r_reg};

  // Gate every result bit with the strobe so out_sum reads zero outside DONE.
  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_out_gate
      assign out_sum[gi] = out_valid & result[gi];
    end
  endgenerate

endmodule
